// File: rtl/coletor_digitos.sv
// Keypad digit collector: assembles up to MAX_DIGITS key codes (newest at digit 0)
// and presents the finished entry with a one-cycle digitos_valid on '#'.
module coletor_digitos #(
  parameter int MAX_DIGITS     = 20,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              enable,
  input  logic [3:0]                        key_value,
  input  logic                              key_valid,
  output logic [4*MAX_DIGITS-1:0]           digitos_value,
  output logic                              digitos_valid,
  output logic [4*MAX_DIGITS-1:0]           buffer_value,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_count,
  output logic                              timeout_pulse
);

  // state  | meaning
  // IDLE   | collection disabled, buffer held empty
  // COLETA | accepting keys, inactivity timer running while buffer non-empty
  // ENVIA  | one-cycle digitos_valid for the entry just submitted

  localparam int CW = $clog2(MAX_DIGITS+1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = 4*MAX_DIGITS;

  localparam logic [BW-1:0] ALL_F     = {BW{1'b1}};
  localparam logic [CW-1:0] CNT_MAX   = CW'(MAX_DIGITS);
  localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT_CYCLES-1);

  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    COLETA = 2'd1,
    ENVIA  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [BW-1:0] out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          tp_q, tp_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      buf_q   <= ALL_F;
      out_q   <= ALL_F;
      cnt_q   <= '0;
      timer_q <= '0;
      tp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      tp_q    <= tp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    tp_d    = 1'b0;

    case (state_q)
      IDLE: begin
        buf_d   = ALL_F;
        cnt_d   = '0;
        timer_d = '0;
        if (enable) state_d = COLETA;
      end

      COLETA: begin
        if (!enable) begin
          buf_d   = ALL_F;
          cnt_d   = '0;
          timer_d = '0;
          state_d = IDLE;
        end else if (key_valid) begin
          // Any key pulse pre-empts a coincident timeout expiry.
          if (key_value <= 4'd9) begin
            if (cnt_q < CNT_MAX) begin
              buf_d = {buf_q[BW-5:0], key_value};
              cnt_d = cnt_q + 1'b1;
            end
            timer_d = '0;
          end else if (key_value == KEY_STAR) begin
            if (cnt_q != '0) begin
              buf_d   = {4'hF, buf_q[BW-1:4]};
              cnt_d   = cnt_q - 1'b1;
              timer_d = '0;
            end
          end else if (key_value == KEY_HASH) begin
            if (cnt_q != '0) begin
              out_d   = buf_q;
              buf_d   = ALL_F;
              cnt_d   = '0;
              timer_d = '0;
              state_d = ENVIA;
            end
          end
        end else if (cnt_q != '0) begin
          if (timer_q == TIMER_END) begin
            buf_d   = ALL_F;
            cnt_d   = '0;
            timer_d = '0;
            tp_d    = 1'b1;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end else begin
          timer_d = '0;
        end
      end

      ENVIA: begin
        buf_d   = ALL_F;
        cnt_d   = '0;
        timer_d = '0;
        state_d = enable ? COLETA : IDLE;
      end

      default: begin
        buf_d   = ALL_F;
        cnt_d   = '0;
        timer_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign digitos_value = out_q;
  assign digitos_valid = (state_q == ENVIA);
  assign buffer_value  = buf_q;
  assign digit_count   = cnt_q;
  assign timeout_pulse = tp_q;

endmodule

// File: doc/coletor_digitos.md
Name: coletor_digitos

Overview:
- Keypad-side producer of the `digitos_value`/`digitos_valid` interface consumed by the lock's setup and authentication FSMs.
- Accepts one decoded key code per pulse and assembles up to MAX_DIGITS digits into a senhaPac_t word, most recent digit at index 0.
- On '#' it issues a one-cycle `digitos_valid` with the assembled word.
- Supports '*' backspace, inactivity timeout and enable gating.

Parameters:
- MAX_DIGITS, 20, capacity of the digit buffer; equals senhaPac_t depth (4 bits per digit).
- TIMEOUT_CYCLES, 5000, idle clock cycles after the last key before a partial entry is discarded; must be ≥2.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  collection allowed; low forces IDLE.
- key_value  input  4  key code: 0–9 digit, 4'hA '*', 4'hB '#', 4'hC–4'hF ignored.
- key_valid  input  1  one-cycle pulse per debounced key press.
- digitos_value  output  4*MAX_DIGITS  (senhaPac_t) last submitted entry, digit[0] most recent, unused digits 4'hF.
- digitos_valid  output  1  one-cycle pulse: digitos_value holds a new entry.
- buffer_value  output  4*MAX_DIGITS  live in-progress buffer, same format; drives display.
- digit_count  output  $clog2(MAX_DIGITS+1)  digits currently in buffer.
- timeout_pulse  output  1  one-cycle pulse when a partial entry is discarded by timeout.

Behaviour:
- All state changes occur on posedge clk; rst is sampled only at posedge clk.
- Reset values:
  - state = IDLE.
  - buffer_value and digitos_value = all digits 4'hF.
  - digit_count = 0.
  - digitos_valid = 0, timeout_pulse = 0.
  - timer = 0.
- States: IDLE, COLETA, ENVIA.
- IDLE:
  - Buffer held at all-F and count held at 0.
  - key_valid is ignored.
  - enable=1 → COLETA on the next edge.
- COLETA, with key_valid=1:
  - Digit 0–9 and count<MAX_DIGITS: buffer shifts up one digit (digit[i+1]←digit[i]), digit[0]←key_value, count+1, timer cleared.
  - Digit 0–9 and count==MAX_DIGITS: key dropped, buffer unchanged, timer cleared.
  - '*' and count>0: buffer shifts down (digit[i]←digit[i+1]), top digit←4'hF, count−1, timer cleared.
  - '*' and count==0: no effect.
  - '#' and count>0: digitos_value←buffer, buffer←all-F, count←0, timer←0, → ENVIA.
  - '#' and count==0: ignored; no valid pulse.
  - Codes 4'hC–4'hF: ignored; timer is not cleared.
- COLETA timer:
  - Increments each cycle while count>0 and key_valid=0.
  - When the timer reaches TIMEOUT_CYCLES−1: buffer←all-F, count←0, timer←0, timeout_pulse=1 for the following cycle.
  - Timer is held at 0 while count==0.
- Simultaneous key_valid and timer expiry: the key is processed, the timeout does not fire, and the timer restarts.
- ENVIA:
  - digitos_valid=1 for exactly this one cycle.
  - key_valid in ENVIA is dropped.
  - Next state: COLETA if enable=1, else IDLE.
- Latency: '#' accepted at edge N → digitos_valid high during cycle N+1 → low at N+2.
- digitos_value changes only on an accepted '#' or rst; it stays stable after the pulse.
- enable=0 in COLETA or ENVIA:
  - Next edge: buffer cleared, count=0, timer=0, → IDLE.
  - A '#' arriving on the same edge is ignored.
  - An ENVIA pulse already in progress still completes its single cycle.
- rst mid-operation: all outputs return to reset values on that edge; no valid pulse is emitted.
- Width rules:
  - digit_count saturates at MAX_DIGITS.
  - The timer is $clog2(TIMEOUT_CYCLES) bits.
  - No arithmetic is performed on digit values.

Test Plan:
1. enable=1; keys 1,2,3,4,'#' → digitos_valid pulse 1 cycle after '#'; digitos_value low digits [3:0]=4,3,2,1 (digit0=4, digit3=1), digits 4–19 = F; digit_count=0 after.
2. Keys 5,6,'*',7,'#' → digitos_value digit0=7, digit1=5, rest F; buffer_value shows 5,6 then 5 then 5,7 along the way.
3. 21 digits 0..9,0..9,3 then '#' → digit_count saturates at 20, the 21st key is dropped, digit0=9; '*' with an empty buffer and '#' with an empty buffer → no change, no valid.
4. Key 8 then TIMEOUT_CYCLES idle cycles → timeout_pulse exactly once; buffer all-F; count 0. Key 9 landing on the expiry cycle → no timeout, count=2.
5. Keys 1,2 then enable=0 → IDLE, buffer cleared; '#' while IDLE → no valid. rst asserted the cycle after '#' → no valid pulse, digitos_value all-F.
